// File: rtl/rcpu_mem_seq.sv
// rcpu_mem_seq: splits one multi-word core request into consecutive single-word
// memory bus cycles at incrementing (wrapping) addresses, with wait-state
// tolerance through memReady and a per-word timeout that aborts with err.
module rcpu_mem_seq #(
  parameter int M         = 16,
  parameter int N         = 32,
  parameter int WORDS_MAX = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           we,
  input  logic [N-1:0]                   addr,
  input  logic [$clog2(WORDS_MAX+1)-1:0] len,
  input  logic [M*WORDS_MAX-1:0]         wdata,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [M*WORDS_MAX-1:0]         rdata,
  output logic [N-1:0]                   memAddr,
  output logic [M-1:0]                   memWrite,
  output logic                           memRE,
  output logic                           memWE,
  input  logic [M-1:0]                   memRead,
  input  logic                           memReady
);

  localparam int LW = $clog2(WORDS_MAX + 1);
  localparam int KW = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LW-1:0] LEN_MAX = LW'(WORDS_MAX);
  localparam logic [WW-1:0] W_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   we_q;
  logic [N-1:0]           addr_q;
  logic [LW-1:0]          len_q;
  logic [M*WORDS_MAX-1:0] wdata_q;
  logic [KW-1:0]          k_q;
  logic [WW-1:0]          w_q;

  logic len_ok;
  logic last_word;
  logic timeout_hit;

  // Request qualification and per-word termination conditions.
  assign len_ok      = (len != '0) && (len <= LEN_MAX);
  assign last_word   = (LW'(k_q) == len_q - LW'(1));
  assign timeout_hit = (TIMEOUT != 0) && !memReady && (w_q == W_LAST);

  // State register; reset drops the FSM to IDLE asynchronously so the decoded
  // strobes fall without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff sees the pre-edge value of every other register.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and Moore output decode from the registered state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    memRE    = 1'b0;
    memWE    = 1'b0;
    memAddr  = '0;
    memWrite = '0;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = len_ok ? ACCESS : DONE;
      end
      ACCESS: begin
        busy    = 1'b1;
        memRE   = ~we_q;
        memWE   = we_q;
        memAddr = addr_q + N'(k_q);
        if (we_q) memWrite = wdata_q[int'(k_q)*M +: M];
        if (memReady) begin
          if (last_word) state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, word index, wait counter, read-data capture and error flag.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the wdata/rdata word arrays are small register banks, not RAM
    // macros, so they are reset along with the control state; this keeps the
    // observable rdata at 0 after reset.
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      w_q     <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            len_q   <= len;
            wdata_q <= wdata;
            k_q     <= '0;
            w_q     <= '0;
            rdata   <= '0;
            err     <= ~len_ok;
          end
        end
        ACCESS: begin
          if (memReady) begin
            if (!we_q) rdata[int'(k_q)*M +: M] <= memRead;
            if (!last_word) begin
              k_q <= k_q + KW'(1);
              w_q <= '0;
            end
          end else if (TIMEOUT != 0) begin
            w_q <= w_q + WW'(1);
            if (timeout_hit) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpu_mem_seq.sv
// Directed self-checking bench for rcpu_mem_seq (M=16, N=32, WORDS_MAX=2,
// TIMEOUT=15). Inputs change 1 ns after each rising edge; outputs are checked
// at that point, i.e. they show the cycle that edge started.
module tb_rcpu_mem_seq;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  len;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] memAddr;
  logic [15:0] memWrite;
  logic        memRE;
  logic        memWE;
  logic [15:0] memRead;
  logic        memReady;

  int checks = 0;
  int errors = 0;

  rcpu_mem_seq #(
    .M(16), .N(32), .WORDS_MAX(2), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .memAddr(memAddr), .memWrite(memWrite), .memRE(memRE), .memWE(memWE),
    .memRead(memRead), .memReady(memReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " memRE"}, 64'(memRE), 64'd0);
    check({tag, " memWE"}, 64'(memWE), 64'd0);
    check({tag, " memAddr"}, 64'(memAddr), 64'd0);
    check({tag, " memWrite"}, 64'(memWrite), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; len = '0; wdata = '0;
    memRead = '0; memReady = 1'b0;

    // ---- reset state
    tick(); tick();
    check_idle_outputs("reset");
    check("reset err", 64'(err), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    rst = 1'b1;
    tick();

    // ---- zero-wait read, two words
    req = 1'b1; we = 1'b0; addr = 32'h0000_1000; len = 2'd2;
    memReady = 1'b1; memRead = 16'h1234;
    tick();                                   // edge 0
    req = 1'b0;
    check("rd0 busy", 64'(busy), 64'd1);
    check("rd0 memAddr", 64'(memAddr), 64'h1000);
    check("rd0 memRE", 64'(memRE), 64'd1);
    check("rd0 memWE", 64'(memWE), 64'd0);
    tick();                                   // cycle 2
    memRead = 16'hABCD;
    check("rd1 memAddr", 64'(memAddr), 64'h1001);
    check("rd1 memRE", 64'(memRE), 64'd1);
    check("rd1 done early", 64'(done), 64'd0);
    tick();                                   // cycle 3
    check("rd done", 64'(done), 64'd1);
    check("rd err", 64'(err), 64'd0);
    check("rd strobe off", 64'(memRE), 64'd0);
    check("rd rdata", 64'(rdata), 64'hABCD_1234);
    tick();                                   // cycle 4
    check("rd idle busy", 64'(busy), 64'd0);
    check("rd done one cycle", 64'(done), 64'd0);
    check("rd rdata held", 64'(rdata), 64'hABCD_1234);

    // ---- wait-state write: word 0 stalls three cycles
    req = 1'b1; we = 1'b1; addr = 32'h20; len = 2'd2; wdata = 32'hBEEF_CAFE;
    memReady = 1'b0;
    tick();                                   // edge 0
    req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      memReady = (i == 4);
      check($sformatf("wr w0 memWrite c%0d", i), 64'(memWrite), 64'hCAFE);
      check($sformatf("wr w0 memAddr c%0d", i), 64'(memAddr), 64'h20);
      check($sformatf("wr w0 memWE c%0d", i), 64'(memWE), 64'd1);
      tick();
    end
    check("wr w1 memWrite", 64'(memWrite), 64'hBEEF);
    check("wr w1 memAddr", 64'(memAddr), 64'h21);
    check("wr w1 memRE", 64'(memRE), 64'd0);
    tick();                                   // cycle 6
    check("wr done", 64'(done), 64'd1);
    check("wr err", 64'(err), 64'd0);
    check("wr memWE off", 64'(memWE), 64'd0);
    tick();

    // ---- address wrap
    req = 1'b1; we = 1'b0; addr = 32'hFFFF_FFFF; len = 2'd2;
    memReady = 1'b1; memRead = 16'h0001;
    tick();
    req = 1'b0;
    check("wrap w0 memAddr", 64'(memAddr), 64'hFFFF_FFFF);
    tick();
    check("wrap w1 memAddr", 64'(memAddr), 64'h0);
    check("wrap w1 memRE", 64'(memRE), 64'd1);
    tick();
    check("wrap done", 64'(done), 64'd1);
    tick();

    // ---- timeout on word 1
    req = 1'b1; we = 1'b0; addr = 32'h40; len = 2'd2;
    memReady = 1'b1; memRead = 16'h5555;
    tick();                                   // cycle 1: word 0
    req = 1'b0;
    check("to w0 memAddr", 64'(memAddr), 64'h40);
    tick();                                   // cycle 2: word 1 begins
    memReady = 1'b0; memRead = 16'h9999;
    check("to w1 memAddr", 64'(memAddr), 64'h41);
    n = 0;
    while (memRE && n < 40) begin
      n++;
      tick();
    end
    check("to strobe cycles", 64'(n), 64'd15);
    check("to done", 64'(done), 64'd1);
    check("to err", 64'(err), 64'd1);
    check("to rdata", 64'(rdata), 64'h0000_5555);
    tick();
    check("to err held", 64'(err), 64'd1);
    check("to done one cycle", 64'(done), 64'd0);

    // ---- illegal lengths
    req = 1'b1; we = 1'b1; addr = 32'h60; len = 2'd0; memReady = 1'b1;
    tick();
    req = 1'b0;
    check("len0 done", 64'(done), 64'd1);
    check("len0 err", 64'(err), 64'd1);
    check("len0 memRE", 64'(memRE), 64'd0);
    check("len0 memWE", 64'(memWE), 64'd0);
    tick();
    check("len0 idle", 64'(busy), 64'd0);
    req = 1'b1; we = 1'b0; len = 2'd3;
    tick();
    req = 1'b0;
    check("len3 done", 64'(done), 64'd1);
    check("len3 err", 64'(err), 64'd1);
    check("len3 memRE", 64'(memRE), 64'd0);
    tick();

    // ---- request during ACCESS is ignored
    req = 1'b1; we = 1'b0; addr = 32'h80; len = 2'd1; memReady = 1'b0;
    memRead = 16'h4242;
    tick();                                   // cycle 1: stalled
    req = 1'b1; we = 1'b1; addr = 32'h99; len = 2'd2;
    tick();                                   // edge 1 must ignore req
    req = 1'b0; memReady = 1'b1;
    check("ign memAddr", 64'(memAddr), 64'h80);
    check("ign memRE", 64'(memRE), 64'd1);
    check("ign memWE", 64'(memWE), 64'd0);
    tick();                                   // cycle 3
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n++;
      tick();
    end
    check("ign done count", 64'(n), 64'd1);
    check("ign err", 64'(err), 64'd0);
    check("ign rdata", 64'(rdata), 64'h0000_4242);
    check("ign idle", 64'(busy), 64'd0);

    // ---- reset in the middle of word 1 of a write
    req = 1'b1; we = 1'b1; addr = 32'h300; len = 2'd2; wdata = 32'h1111_2222;
    memReady = 1'b1;
    tick();                                   // cycle 1: word 0
    req = 1'b0;
    tick();                                   // cycle 2: word 1
    memReady = 1'b0;
    check("rst w1 memWE", 64'(memWE), 64'd1);
    check("rst w1 memAddr", 64'(memAddr), 64'h301);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("rst async");
    check("rst async err", 64'(err), 64'd0);
    check("rst async rdata", 64'(rdata), 64'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || memWE) n++;
    end
    check("rst no activity", 64'(n), 64'd0);
    #3 rst = 1'b1;
    tick();
    req = 1'b1; we = 1'b0; addr = 32'h500; len = 2'd1;
    memReady = 1'b1; memRead = 16'h7777;
    tick();
    req = 1'b0;
    check("post rst memAddr", 64'(memAddr), 64'h500);
    check("post rst memRE", 64'(memRE), 64'd1);
    tick();
    check("post rst done", 64'(done), 64'd1);
    check("post rst err", 64'(err), 64'd0);
    check("post rst rdata", 64'(rdata), 64'h0000_7777);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rcpu_mem_seq.md
# rcpu_mem_seq

Parametrised memory access sequencer between the RCPU control unit and external memory. The core issues one request for a multi-word read or write (e.g. a 32-bit PC load or push as two 16-bit words); the block splits it into consecutive single-word bus cycles at incrementing addresses. It tolerates memory wait states through a ready input, and aborts with an error flag on a per-word timeout. Until now the core assumed single-cycle memory.

## Interface
- M, 16: data bus width (bits per word)
- N, 32: address bus width
- WORDS_MAX, 2: maximum words per request (≥1)
- TIMEOUT, 15: maximum wait cycles per word; 0 disables the timeout
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  1  request strobe from core
- we  in  1  1 = write, 0 = read (sampled with req)
- addr  in  N  base word address
- len  in  clog2(WORDS_MAX+1)  word count, 1..WORDS_MAX
- wdata  in  M*WORDS_MAX  write data; word k at bits [M*k +: M]
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle completion pulse
- err  out  1  error status of the last completed request, valid with done and held after it
- rdata  out  M*WORDS_MAX  read data; word k at bits [M*k +: M]
- memAddr  out  N  memory address
- memWrite  out  M  memory write data
- memRE  out  1  memory read enable
- memWE  out  1  memory write enable
- memRead  in  M  memory read data
- memReady  in  1  memory has completed the current word this cycle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **Reset state:** IDLE; busy, done, err, memRE, memWE = 0; rdata, memAddr, memWrite = 0.
- **IDLE:**
  - req is sampled here only; req in ACCESS/DONE is ignored (no queueing).
  - On req with 1 ≤ len ≤ WORDS_MAX: latch we, addr, len, wdata; clear rdata and err; set index k=0 and wait counter w=0; go to ACCESS.
  - On req with len=0 or len>WORDS_MAX: no memory access; err=1; go to DONE.
- **ACCESS:**
  - Outputs: memAddr = (addr + k) mod 2^N, so the address wraps from all-ones to 0. memRE = ~we. memWE = we. memWrite = wdata word k for writes, otherwise 0.
  - If memReady=1:
    - On a read, capture memRead into rdata word k.
    - If k = len-1, go to DONE; otherwise k=k+1 and w=0.
  - If memReady=0 and TIMEOUT≠0: w=w+1. When memReady=0 and w = TIMEOUT-1, set err=1 and go to DONE.
  - After a timeout, rdata words already captured stay valid; the remaining words stay 0.
- **DONE:** done=1 for exactly one cycle, then IDLE. memRE and memWE are 0.
- **busy** is 1 in ACCESS and DONE, 0 in IDLE.
- rdata and err hold their values until the next accepted req.
- Reset asserted mid-request: the FSM returns to IDLE and strobes drop asynchronously. No done pulse is produced and no further words are written.

## Timing
- Strobes and memAddr are decoded from registered state (Moore). memReady and memRead are sampled on the clock edge ending each bus cycle.
- Zero-wait request of L words accepted at edge 0:
  - ACCESS during cycles 1..L.
  - done high in cycle L+1.
  - IDLE in cycle L+2; next req accepted at the edge ending cycle L+2.
- Each wait cycle adds one cycle. One word holds its strobe for at most TIMEOUT cycles.
- Abort timing: the timeout abort happens at the edge ending the TIMEOUT-th consecutive not-ready cycle; done follows in the next cycle.
- An invalid-len request gives done in cycle 1.
- memReady asserted outside ACCESS is ignored.

## Test plan
- **Zero-wait read:** read, addr=0x00001000, len=2, memReady tied 1, memory returns 0x1234 then 0xABCD -> memAddr 0x1000 then 0x1001 with memRE=1; done in cycle 3; rdata=0xABCD1234; err=0.
- **Wait-state write:** write, addr=0x20, len=2, wdata=0xBEEF_CAFE, memReady low 3 cycles on word 0 -> memWrite=0xCAFE held 4 cycles at 0x20, then 0xBEEF at 0x21; done in cycle 6; err=0.
- **Address wrap:** read at addr=0xFFFFFFFF, len=2 -> memAddr 0xFFFFFFFF then 0x00000000.
- **Timeout:** read, len=2, memReady=1 on word 0 (0x5555), then held 0 -> word 1 strobe lasts exactly 15 cycles; done next; err=1; rdata=0x00005555.
- **Illegal length and ignored request:** len=0 -> done in cycle 1, err=1, memRE/memWE never asserted. req pulsed during ACCESS -> ignored; exactly one done.
- **Reset mid-request:** rst driven low in the middle of word 1 of a write -> memWE drops immediately; all outputs 0; no done; a new req after reset release completes normally.
